machine_timer_irq: RTL
======================

Name: machine_timer_irq

Overview:
- Memory-mapped machine timer and interrupt source block, directly upstream of the CSR unit.
- Owns the 64-bit mtime/mtimecmp pair, the machine software-interrupt bit (msip) and the external-interrupt synchronizer.
- Drives level interrupt lines into the CSR unit's mip bits 7 (timer), 3 (software) and 11 (external).
- Accessed by the load/store stage over a single-beat request/response port.

Parameters:
- PRESCALE, 1, clk cycles per mtime increment (>=1).
- SYNC_STAGES, 2, flops in the ext_irq_async synchronizer (>=2).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  access request this cycle
- req_write  input  1  1=write, 0=read
- req_addr  input  5  byte offset: 0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo, 0x0C mtimecmp_hi, 0x10 msip
- req_wdata  input  32  write data
- req_priv  input  2  privilege of requester (2'b11 = machine)
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  read data, valid with rsp_valid
- rsp_err  output  1  access fault, valid with rsp_valid
- ext_irq_async  input  1  asynchronous external interrupt level
- timer_irq  output  1  to mip[7]
- soft_irq  output  1  to mip[3]
- ext_irq  output  1  to mip[11]

Behaviour:
Reset (reset low, asynchronous):
- mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescale counter=0, hi shadow=0, synchronizer flops=0.
- All outputs 0.

Timebase:
- Prescale counter counts 0..PRESCALE-1.
- mtime increments by 1 on the cycle the counter equals PRESCALE-1; the counter then returns to 0.
- PRESCALE=1: mtime increments every cycle.
- mtime wraps from 2^64-1 to 0 with no flag.

Bus:
- Always ready: one request accepted per cycle when req_valid=1.
- rsp_valid asserted exactly 1 cycle after acceptance, deasserted otherwise.
- rsp_rdata=0 whenever rsp_valid=0.
- Error cases: req_priv != 2'b11, or req_addr not in {0x00,0x04,0x08,0x0C,0x10}, or req_addr[1:0] != 0.
  - Response: rsp_err=1, rsp_rdata=0, no state change, shadow unchanged.

Reads (value sampled in the accept cycle):
- 0x00 returns mtime[31:0] and copies mtime[63:32] into the hi shadow in the same cycle.
- 0x04 returns the hi shadow, not live mtime[63:32].
- 0x08 / 0x0C return mtimecmp halves.
- 0x10 returns {31'b0, msip}.

Writes (take effect at the end of the accept cycle):
- A write to mtime_lo or mtime_hi replaces that half.
  - The increment due that cycle is dropped for the written half only.
  - A carry from lo into hi is also dropped when hi is written.
  - The prescale counter resets to 0.
- A write to msip stores wdata[0]; upper bits are ignored.

Interrupts:
- timer_irq registered: timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare on the current registered values. This gives 1 cycle of latency after the compare becomes true or false.
- soft_irq = msip (registered bit).
- ext_irq = last stage of the SYNC_STAGES synchronizer, giving SYNC_STAGES cycles of latency.
- All three are levels with no internal clearing. Software clears them by:
  - rewriting mtimecmp (timer),
  - writing msip=0 (software),
  - deasserting the source (external).

Simultaneous events:
- A bus write and the compare in the same cycle: the compare uses pre-write values, and the next cycle reflects the write.
- Reset mid-request: no rsp_valid is produced for a request in flight.

Test Plan:
1. Reset release, PRESCALE=1, idle 10 cycles -> read 0x00 returns 10±1 (fixed by bench alignment), read 0x04 returns 0; timer_irq=0, soft_irq=0, ext_irq=0 throughout.
2. Write 0x0C=0, then 0x08=20 with mtime<20 -> timer_irq rises on the cycle after mtime reaches 20; write 0x08=0xFFFF_FFFF and 0x0C=0xFFFF_FFFF -> timer_irq falls 1 cycle after the second write completes.
3. Write 0x00=0xFFFF_FFFE, 0x04=0 -> after 2 increments mtime=0x1_0000_0000; a read of 0x00 then 0x04 returns lo=0 (or 1 if the bench aligns it) and hi=1 from the shadow even if lo rolls over between the two reads.
4. Write 0x10=0xFFFF_FFFF -> soft_irq=1 next cycle, read 0x10 returns 1; write 0x10=0 -> soft_irq=0.
5. Read 0x14, read 0x02, and write 0x10 with req_priv=2'b00 -> each gives rsp_err=1, rsp_rdata=0, msip unchanged.
6. Pulse ext_irq_async high for 3 cycles with SYNC_STAGES=2 -> ext_irq high for 3 cycles starting 2 cycles later; assert reset mid-pulse -> ext_irq=0 immediately, and mtime=0 on release.

Source files
------------

// File: rtl/machine_timer_irq.sv
// Machine timer and interrupt source: 64-bit mtime/mtimecmp, msip bit and
// external interrupt synchronizer, exposed over a single-beat register port.
// The interrupt outputs are levels feeding mip[7], mip[3] and mip[11].
module machine_timer_irq #(
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_priv,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        ext_irq_async,
  output logic        timer_irq,
  output logic        soft_irq,
  output logic        ext_irq
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  localparam logic [4:0] ADDR_MTIME_LO = 5'h00;
  localparam logic [4:0] ADDR_MTIME_HI = 5'h04;
  localparam logic [4:0] ADDR_CMP_LO   = 5'h08;
  localparam logic [4:0] ADDR_CMP_HI   = 5'h0C;
  localparam logic [4:0] ADDR_MSIP     = 5'h10;

  logic [63:0]            mtime_q, mtime_d;
  logic [63:0]            cmp_q, cmp_d;
  logic                   msip_q, msip_d;
  logic [31:0]            shadow_q, shadow_d;
  logic [CNT_W-1:0]       prescCnt_q, prescCnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   timer_q, timer_d;
  logic                   rspValid_q, rspValid_d;
  logic [31:0]            rspRdata_q, rspRdata_d;
  logic                   rspErr_q, rspErr_d;

  logic                   addrOk;
  logic                   accessErr;
  logic                   rdEn;
  logic                   wrEn;
  logic                   tick;

  // Decode the request: unmapped offsets, misaligned offsets and non-machine
  // requesters fault and must not touch any state, including the hi shadow.
  always_comb begin
    addrOk    = (req_addr == ADDR_MTIME_LO) || (req_addr == ADDR_MTIME_HI) ||
                (req_addr == ADDR_CMP_LO)   || (req_addr == ADDR_CMP_HI)   ||
                (req_addr == ADDR_MSIP);
    accessErr = (req_priv != 2'b11) || !addrOk;
    rdEn      = req_valid && !accessErr && !req_write;
    wrEn      = req_valid && !accessErr &&  req_write;
    tick      = (prescCnt_q == CNT_MAX);
  end

  // Next-state for timebase, registers and response. A write to one mtime
  // half overrides only that half of the incremented value, so the other half
  // still advances (lo write keeps the carry into hi; hi write drops it).
  always_comb begin
    mtime_d    = mtime_q + {63'd0, tick};
    prescCnt_d = tick ? '0 : prescCnt_q + CNT_W'(1);
    cmp_d      = cmp_q;
    msip_d     = msip_q;
    shadow_d   = shadow_q;
    rspValid_d = req_valid;
    rspErr_d   = req_valid && accessErr;
    rspRdata_d = '0;
    timer_d    = (mtime_q >= cmp_q);

    if (rdEn) begin
      case (req_addr)
        ADDR_MTIME_LO: begin
          rspRdata_d = mtime_q[31:0];
          shadow_d   = mtime_q[63:32];
        end
        ADDR_MTIME_HI: rspRdata_d = shadow_q;
        ADDR_CMP_LO:   rspRdata_d = cmp_q[31:0];
        ADDR_CMP_HI:   rspRdata_d = cmp_q[63:32];
        ADDR_MSIP:     rspRdata_d = {31'd0, msip_q};
        default:       rspRdata_d = '0;
      endcase
    end

    if (wrEn) begin
      case (req_addr)
        ADDR_MTIME_LO: begin
          mtime_d[31:0] = req_wdata;
          prescCnt_d    = '0;
        end
        ADDR_MTIME_HI: begin
          mtime_d[63:32] = req_wdata;
          prescCnt_d     = '0;
        end
        ADDR_CMP_LO:   cmp_d[31:0]  = req_wdata;
        ADDR_CMP_HI:   cmp_d[63:32] = req_wdata;
        ADDR_MSIP:     msip_d       = req_wdata[0];
        default:       msip_d       = msip_q;
      endcase
    end
  end

  // State registers; reset also kills any response still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q    <= '0;
      cmp_q      <= '1;
      msip_q     <= 1'b0;
      shadow_q   <= '0;
      prescCnt_q <= '0;
      timer_q    <= 1'b0;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      msip_q     <= msip_d;
      shadow_q   <= shadow_d;
      prescCnt_q <= prescCnt_d;
      timer_q    <= timer_d;
      rspValid_q <= rspValid_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
    end
  end

  // Multi-flop synchronizer bringing the asynchronous external level into clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq_async};
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;
  assign timer_irq = timer_q;
  assign soft_irq  = msip_q;
  assign ext_irq   = sync_q[SYNC_STAGES-1];

endmodule
